// File: rtl/shift_add_mult.sv
// rtl/shift_add_mult.sv - sequential unsigned shift-and-add multiplier with start/busy/done handshake
module shift_add_mult #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   p_q;
    logic [WIDTH-1:0]     m_q;
    logic                 c_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     q_q;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH:0]       sum_d;
    logic                 last_d;

    // C is zero between iterations, so {C,A} never overflows WIDTH+1 bits.
    always_comb begin
        sum_d  = {c_q, a_q} + {1'b0, m_q & {WIDTH{q_q[0]}}};
        last_d = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            p_q     <= '0;
            m_q     <= '0;
            c_q     <= 1'b0;
            a_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        m_q     <= mcand;
                        q_q     <= mplier;
                        a_q     <= '0;
                        c_q     <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // Add and shift in one edge: the carry lands in A's MSB.
                    {c_q, a_q, q_q} <= {1'b0, sum_d, q_q[WIDTH-1:1]};
                    cnt_q           <= cnt_q + CW'(1);
                    if (last_d) begin
                        p_q     <= {sum_d, q_q[WIDTH-1:1]};
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// tb/tb_shift_add_mult.sv - directed bench for shift_add_mult at WIDTH=4 and WIDTH=8
module tb_shift_add_mult;

    logic        clk = 1'b0;
    logic        clr;
    logic        start4, start8;
    logic [3:0]  mcand4, mplier4;
    logic [7:0]  mcand8, mplier8;
    logic        busy4, done4, busy8, done8;
    logic [7:0]  p4;
    logic [15:0] p8;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    shift_add_mult #(.WIDTH(4)) dut4 (
        .clk(clk), .clr(clr), .start(start4), .mcand(mcand4), .mplier(mplier4),
        .busy(busy4), .done(done4), .p(p4)
    );

    shift_add_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .clr(clr), .start(start8), .mcand(mcand8), .mplier(mplier8),
        .busy(busy8), .done(done8), .p(p8)
    );

    // Drives one operation and reports what was observed; done_at counts rising edges from the start drive.
    task automatic do_op(input bit wide, input logic [7:0] a, input logic [7:0] b,
                         output int done_at, output logic [15:0] p_at,
                         output logic busy_e1, output logic busy_after, output logic done_after);
        done_at    = -1;
        p_at       = '0;
        busy_after = 1'b1;
        done_after = 1'b1;
        @(negedge clk);
        if (wide) begin mcand8 = a; mplier8 = b; start8 = 1'b1; end
        else begin mcand4 = a[3:0]; mplier4 = b[3:0]; start4 = 1'b1; end
        @(negedge clk);
        start4 = 1'b0; start8 = 1'b0;
        mcand4 = ~mcand4; mplier4 = ~mplier4; mcand8 = ~mcand8; mplier8 = ~mplier8;
        busy_e1 = wide ? busy8 : busy4;
        for (int k = 2; k <= 20; k++) begin
            @(negedge clk);
            if ((wide ? done8 : done4) === 1'b1) begin
                done_at = k;
                p_at    = wide ? p8 : {8'h00, p4};
                @(negedge clk);
                busy_after = wide ? busy8 : busy4;
                done_after = wide ? done8 : done4;
                break;
            end
        end
    endtask

    task automatic test_reset;
        clr = 1'b0; start4 = 1'b0; start8 = 1'b0;
        mcand4 = '0; mplier4 = '0; mcand8 = '0; mplier8 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({busy4, done4, p4} !== 10'h0) begin
            miscompares++;
            $display("FAIL reset_w4 busy/done/p=%b/%b/%h want 0/0/00", busy4, done4, p4);
        end
        vectors++;
        if ({busy8, done8, p8} !== 18'h0) begin
            miscompares++;
            $display("FAIL reset_w8 busy/done/p=%b/%b/%h want 0/0/0000", busy8, done8, p8);
        end
        clr = 1'b1;
    endtask

    task automatic test_basic;
        int dat; logic [15:0] pv; logic be1, ba, da;
        do_op(1'b0, 8'd13, 8'd11, dat, pv, be1, ba, da);
        vectors++;
        if (be1 !== 1'b1) begin miscompares++; $display("FAIL basic_busy got %b want 1", be1); end
        vectors++;
        if (dat !== 5) begin miscompares++; $display("FAIL basic_done_edge got %0d want 5", dat); end
        vectors++;
        if (pv !== 16'h008F) begin miscompares++; $display("FAIL basic_p got %h want 8f", pv); end
        vectors++;
        if ({ba, da} !== 2'b00) begin miscompares++; $display("FAIL basic_idle busy/done=%b/%b want 0/0", ba, da); end
    endtask

    task automatic test_boundaries;
        logic [7:0] av [3] = '{8'd15, 8'd15, 8'd0};
        logic [7:0] bv [3] = '{8'd15, 8'd0, 8'd9};
        logic [7:0] ev [3] = '{8'hE1, 8'h00, 8'h00};
        int dat; logic [15:0] pv; logic be1, ba, da;
        for (int i = 0; i < 3; i++) begin
            do_op(1'b0, av[i], bv[i], dat, pv, be1, ba, da);
            vectors++;
            if (dat !== 5) begin miscompares++; $display("FAIL bound%0d_done_edge got %0d want 5", i, dat); end
            vectors++;
            if (pv !== {8'h00, ev[i]}) begin miscompares++; $display("FAIL bound%0d_p got %h want %h", i, pv, ev[i]); end
        end
    endtask

    task automatic test_start_held;
        int n = 0, first = -1, second = -1;
        @(negedge clk);
        mcand4 = 4'd3; mplier4 = 4'd5; start4 = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 10) start4 = 1'b0;
            if (done4 === 1'b1) begin
                n++;
                if (n == 1) first = k;
                if (n == 2) second = k;
                vectors++;
                if (p4 !== 8'd15) begin miscompares++; $display("FAIL held_p got %h want 0f", p4); end
            end
        end
        vectors++;
        if (n !== 2) begin miscompares++; $display("FAIL held_count got %0d want 2", n); end
        vectors++;
        if (first !== 5 || second !== 11) begin
            miscompares++;
            $display("FAIL held_spacing got %0d,%0d want 5,11", first, second);
        end
    endtask

    task automatic test_back_to_back;
        int n = 0, dat = -1; logic [7:0] pv = '0;
        @(negedge clk); mcand4 = 4'd6; mplier4 = 4'd7; start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        @(negedge clk); mcand4 = 4'd9; mplier4 = 4'd9; start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        for (int k = 4; k <= 14; k++) begin
            @(negedge clk);
            if (done4 === 1'b1) begin n++; dat = k; pv = p4; end
        end
        vectors++;
        if (n !== 1 || dat !== 5) begin miscompares++; $display("FAIL b2b_done got count %0d edge %0d want 1 at 5", n, dat); end
        vectors++;
        if (pv !== 8'd42) begin miscompares++; $display("FAIL b2b_p got %h want 2a", pv); end
        vectors++;
        if (p4 !== 8'd42) begin miscompares++; $display("FAIL b2b_p_hold got %h want 2a", p4); end
    endtask

    task automatic test_abort;
        int n = 0, dat; logic [15:0] pv; logic be1, ba, da;
        @(negedge clk); mcand4 = 4'd13; mplier4 = 4'd11; start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        @(negedge clk); clr = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy4, done4, p4} !== 10'h0) begin
            miscompares++;
            $display("FAIL abort_state busy/done/p=%b/%b/%h want 0/0/00", busy4, done4, p4);
        end
        clr = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (done4 === 1'b1) n++;
        end
        vectors++;
        if (n !== 0) begin miscompares++; $display("FAIL abort_no_done got %0d pulses want 0", n); end
        @(negedge clk); clr = 1'b0; start4 = 1'b1;
        @(negedge clk); clr = 1'b1; start4 = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy4 !== 1'b0) begin miscompares++; $display("FAIL reset_beats_start busy got %b want 0", busy4); end
        do_op(1'b0, 8'd13, 8'd11, dat, pv, be1, ba, da);
        vectors++;
        if (dat !== 5 || pv !== 16'h008F) begin
            miscompares++;
            $display("FAIL abort_recover got edge %0d p %h want 5 8f", dat, pv);
        end
    endtask

    task automatic test_wide;
        int dat; logic [15:0] pv; logic be1, ba, da;
        logic [7:0] a, b;
        do_op(1'b1, 8'd255, 8'd255, dat, pv, be1, ba, da);
        vectors++;
        if (dat !== 9 || pv !== 16'hFE01) begin
            miscompares++;
            $display("FAIL w8_allones got edge %0d p %h want 9 fe01", dat, pv);
        end
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            do_op(1'b1, a, b, dat, pv, be1, ba, da);
            vectors++;
            if (dat !== 9) begin miscompares++; $display("FAIL w8_rand_edge %0d*%0d got %0d want 9", a, b, dat); end
            vectors++;
            if (pv !== 16'(a) * 16'(b)) begin
                miscompares++;
                $display("FAIL w8_rand_p %0d*%0d got %0d want %0d", a, b, pv, 16'(a) * 16'(b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_start_held();
        test_back_to_back();
        test_abort();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
